// File: rtl/fifo_drain_serializer.sv
// Pops wide words from an upstream FIFO and replays each one as narrow beats into a downstream enq.
// Beat order is LSB-first by default; define SERIALIZER_MSB_FIRST_EN for MSB-first.
module fifo_drain_serializer #(
  parameter int unsigned width     = 128,
  parameter int unsigned beatWidth = 32
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic [width-1:0]     in_first,
  input  logic                 in_first__RDY,
  input  logic                 in_deq__RDY,
  output logic                 in_deq__ENA,
  input  logic                 out_enq__RDY,
  output logic                 out_enq__ENA,
  output logic [beatWidth-1:0] out_enq_v,
  output logic                 busy
);

  localparam int unsigned beats = width / beatWidth;
  localparam int unsigned CW    = $clog2(beats) + 1;
  localparam logic [CW-1:0] LAST = CW'(beats - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t           state, state_n;
  logic [width-1:0] sr, sr_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             load;
  logic             last;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state <= IDLE;
      sr    <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      sr    <= sr_n;
      cnt   <= cnt_n;
    end
  end

  // Handshakes are gated by nRST so nothing transfers during the reset cycle itself.
  always_comb begin
    state_n      = state;
    sr_n         = sr;
    cnt_n        = cnt;
    load         = in_first__RDY && in_deq__RDY;
    busy         = (state == SEND);
    last         = (cnt == LAST);
    out_enq__ENA = nRST && busy && out_enq__RDY;
    in_deq__ENA  = nRST && load && (!busy || (out_enq__ENA && last));
`ifdef SERIALIZER_MSB_FIRST_EN
    out_enq_v    = sr[width-1 -: beatWidth];
`else
    out_enq_v    = sr[beatWidth-1:0];
`endif

    if (in_deq__ENA) begin
      sr_n    = in_first;
      cnt_n   = '0;
      state_n = SEND;
    end else if (out_enq__ENA) begin
      if (last) begin
        state_n = IDLE;
      end else begin
`ifdef SERIALIZER_MSB_FIRST_EN
        sr_n  = sr << beatWidth;
`else
        sr_n  = sr >> beatWidth;
`endif
        cnt_n = cnt + CW'(1);
      end
    end
  end

endmodule

// File: doc/fifo_drain_serializer.md
# fifo_drain_serializer

Consumer-side companion to the sized FIFO. It pops wide words from a FIFO's `first`/`deq` methods and replays each word as a sequence of narrow beats into a downstream `enq` method. It sits between a wide buffering FIFO and a narrow sink such as a link or a narrow FIFO. It sustains one beat per cycle with no bubble between words.

## Interface
Parameters:
- `width`, 128: bits per upstream word.
- `beatWidth`, 32: bits per output beat. `width % beatWidth == 0` is required. `beats = width/beatWidth`, and `beats >= 1`.

Ports:
- `CLK`  input  1  clock. All state updates on the rising edge.
- `nRST`  input  1  reset. Synchronous, active-low.
- `in$first`  input  width  head word of the upstream FIFO.
- `in$first__RDY`  input  1  head word valid.
- `in$deq__RDY`  input  1  upstream FIFO non-empty.
- `in$deq__ENA`  output  1  pop the upstream head this cycle.
- `out$enq__RDY`  input  1  downstream can accept a beat.
- `out$enq__ENA`  output  1  beat transferred this cycle.
- `out$enq$v`  output  beatWidth  beat data.
- `busy`  output  1  a word is held and has beats remaining.

## Operation
- State: `busy` flag, holding shift register `sr[width-1:0]`, beat counter `cnt[$clog2(beats+0)+1-1:0]`.
- IDLE (`busy`=0):
  - `load = in$first__RDY && in$deq__RDY`. Both signals are required, because upstream `first__RDY` may be tied high.
  - On `load`: assert `in$deq__ENA` combinationally in the same cycle, set `sr <= in$first`, `cnt <= 0`, `busy <= 1`.
- SEND (`busy`=1):
  - `out$enq$v` = current beat slice of `sr`.
  - `out$enq__ENA = busy && out$enq__RDY`. ENA is never asserted without RDY.
  - On a transfer that is not the last beat: shift `sr` by `beatWidth` and increment `cnt`.
  - On a transfer of the last beat (`cnt == beats-1`):
    - If `load` also holds, pop and load the next word in the same cycle (`in$deq__ENA`=1, `cnt <= 0`, `busy` stays 1).
    - Otherwise `busy <= 0`.
- `in$deq__ENA = load && (!busy || (out$enq__ENA && cnt == beats-1))`. The block never pops while beats remain.
- Backpressure (`out$enq__RDY`=0): `sr`, `cnt` and `out$enq$v` hold, and no pop occurs.
- `beats == 1`: every transfer is a last beat, so the block acts as a registered pass-through at one word per cycle.
- Counter arithmetic wraps only through explicit reload to 0. `cnt` never exceeds `beats-1`.

## Timing
- Reset values: `busy`=0, `cnt`=0, `sr`=0, so `out$enq$v`=0, `out$enq__ENA`=0, `in$deq__ENA`=0.
- Latency: word popped in cycle N, first beat presented in cycle N+1. If `out$enq__RDY` is high, that beat transfers in N+1.
- Throughput: 1 beat/cycle. Back-to-back words need `beats` cycles per word with no idle cycle.
- `nRST` low mid-word discards the remaining beats. The popped word is lost, and no beat or pop is issued in the reset cycle or after it.
- Upstream goes empty at the last beat: `busy` drops and the next pop happens in the first cycle `load` holds.
- Simultaneous last-beat transfer and upstream ready: the pop and the final beat occur in the same cycle.

## Configuration
- `SERIALIZER_MSB_FIRST_EN` undefined: LSB-first. The beat is `sr[beatWidth-1:0]` and `sr` shifts right.
- `SERIALIZER_MSB_FIRST_EN` defined: MSB-first. The beat is `sr[width-1:width-beatWidth]` and `sr` shifts left.
- Handshake and timing are identical in both modes.

## Test plan
- `width`=32, `beatWidth`=8, `out$enq__RDY`=1. Upstream word 0xA1B2C3D4 gives beats D4,C3,B2,A1 on 4 consecutive cycles. With `SERIALIZER_MSB_FIRST_EN`, the beats are A1,B2,C3,D4. `busy` is 1 for exactly 4 cycles.
- Words 0x11223344 and 0x55667788 queued upstream gives 8 beats in 8 consecutive cycles. The second `in$deq__ENA` coincides with beat 0x11.
- Drop `out$enq__RDY` for 3 cycles after beat 2 of 0xA1B2C3D4: `out$enq$v` holds at 0xB2, no pop occurs, and the sequence resumes with B2 then A1.
- Upstream empty (`in$deq__RDY`=0, `in$first__RDY`=1): `in$deq__ENA`=0 and `out$enq__ENA`=0 indefinitely.
- Reset asserted after beat 1 of 0xA1B2C3D4: in the following cycles `busy`=0 and `out$enq$v`=0. The next word 0xCAFEF00D starts cleanly with beat 0x0D.
- `width`=`beatWidth`=16 with words 0x1234 and 0x5678 queued: one word per cycle, and each output appears the cycle after its pop.
